hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multi-cycle multiply/divide engine owning HI/LO
module hilo_muldiv_unit #(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        sign_q;
    logic        sign_r;
    logic        dz_pend;

    logic        is_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    // Operand magnitudes at issue; an unsigned 32-bit result holds |-2^31| exactly
    always_comb begin
        is_div = (op == OP_DIV);
        mag_a  = (is_div && a[31]) ? (32'd0 - a) : a;
        mag_b  = (is_div && b[31]) ? (32'd0 - b) : b;
    end

    // Full 64-bit product of the latched operands, sign- or zero-extended
    always_comb begin
        ext_a   = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
        ext_b   = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
        product = ext_a * ext_b;
    end

    // One restoring step: 33-bit trial subtract, borrow in bit 32 means restore
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[32]) begin
            rem_next = trial[31:0];
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = shifted[31:0];
            quo_next = {quo[30:0], 1'b0};
        end
    end

    // Control FSM, datapath registers and the architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            mul_a      <= 32'd0;
            mul_b      <= 32'd0;
            mul_signed <= 1'b0;
            rem        <= 32'd0;
            quo        <= 32'd0;
            dvs        <= 32'd0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            dz_pend    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                mul_a      <= a;
                                mul_b      <= b;
                                mul_signed <= (op == OP_MULT);
                                cnt        <= 6'd0;
                                busy       <= 1'b1;
                                div_zero   <= 1'b0;
                                state      <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                cnt      <= 6'd0;
                                busy     <= 1'b1;
                                div_zero <= 1'b0;
                                if (b == 32'd0) begin
                                    // FIX then writes lo=all-ones, hi=dividend unchanged
                                    quo     <= 32'hFFFF_FFFF;
                                    rem     <= a;
                                    sign_q  <= 1'b0;
                                    sign_r  <= 1'b0;
                                    dz_pend <= 1'b1;
                                    state   <= FIX;
                                end else begin
                                    quo     <= mag_a;
                                    rem     <= 32'd0;
                                    dvs     <= mag_b;
                                    sign_q  <= is_div & (a[31] ^ b[31]);
                                    sign_r  <= is_div & a[31];
                                    dz_pend <= 1'b0;
                                    state   <= DIV;
                                end
                            end
                            OP_MTHI: begin
                                hi       <= a;
                                div_zero <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo       <= a;
                                div_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt == 6'(MUL_STAGES - 1)) begin
                        {hi, lo} <= product;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo       <= sign_q ? (32'd0 - quo) : quo;
                    hi       <= sign_r ? (32'd0 - rem) : rem;
                    div_zero <= dz_pend;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - table-driven bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    hilo_muldiv_unit #(.MUL_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d_done_low", idx), 64'(done), 64'd0);
        if (v.cyc == 0) begin
            chk($sformatf("v%0d_busy_mt", idx), 64'(busy), 64'd0);
        end else begin
            chk($sformatf("v%0d_busy_set", idx), 64'(busy), 64'd1);
            n = 0;
            while (busy && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("v%0d_cycles", idx), 64'(n), 64'(v.cyc));
            chk($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd1);
        end
        chk($sformatf("v%0d_hi", idx), 64'(hi), 64'(v.hi));
        chk($sformatf("v%0d_lo", idx), 64'(lo), 64'(v.lo));
        chk($sformatf("v%0d_div_zero", idx), 64'(div_zero), 64'(v.dz));
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 2,  1'b0};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 2,  1'b0};
        vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
        vecs[3]  = '{3'b011, 32'd100,       32'd7,        32'd2,         32'd14,        33, 1'b0};
        vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33, 1'b0};
        vecs[5]  = '{3'b011, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1,  1'b1};
        vecs[6]  = '{3'b000, 32'd6,         32'd7,        32'd0,         32'd42,        2,  1'b0};
        vecs[7]  = '{3'b100, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'd42,        0,  1'b0};
        vecs[8]  = '{3'b101, 32'h9ABC_DEF0, 32'd0,        32'h1234_5678, 32'h9ABC_DEF0, 0,  1'b0};
        vecs[9]  = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33, 1'b0};
        vecs[10] = '{3'b010, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1,  1'b1};
        vecs[11] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        2,  1'b0};
        vecs[12] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        2,  1'b0};

        // Reset held with a live MULT request
        rst_n = 1'b0; start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_lo", 64'(lo), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Table vectors, issued back to back in the done cycle
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("mthi_hi", 64'(hi), 64'hCAFE_F00D);
        chk("mthi_lo", 64'(lo), 64'd1);
        chk("mthi_busy", 64'(busy), 64'd0);
        op = 3'b101; a = 32'h0BAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h0BAD_BEEF);
        chk("mtlo_hi", 64'(hi), 64'hCAFE_F00D);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);

        // Reserved op is a no-op
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 32'h0000_FFFF; b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rsv_busy", 64'(busy), 64'd0);
        chk("rsv_done", 64'(done), 64'd0);
        chk("rsv_hi", 64'(hi), 64'hCAFE_F00D);
        chk("rsv_lo", 64'(lo), 64'h0BAD_BEEF);

        // Start during a division is ignored
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_lo_hold", 64'(lo), 64'h0BAD_BEEF);
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("ign_cycles", 64'(n), 64'd28);
        end
        chk("ign_lo", 64'(lo), 64'd14);
        chk("ign_hi", 64'(hi), 64'd2);

        // Reset in the middle of a division
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 2, 1'b0}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
